// File: rtl/inv_park_clarke.sv
// Inverse Park + inverse Clarke: (vd, vq, sin, cos) -> (va, vb, vc).
// One shared signed multiplier is stepped over five compute states.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | in_ready=1, operands captured on in_valid
// M0     | acc = vd*cos
// M1     | acc -= vq*sin, valpha = sat(acc>>>F)
// M2     | acc = vd*sin
// M3     | acc += vq*cos, vbeta = sat(acc>>>F)
// M4     | va/vb/vc from valpha and vbeta*K_SQRT3_2
// OUT    | out_valid=1, results held until out_ready

module inv_park_clarke #(
    parameter int N         = 10,
    parameter int F         = 9,
    parameter int K_SQRT3_2 = 443
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] vd,
    input  logic signed [N-1:0] vq,
    input  logic signed [N-1:0] sin_theta,
    input  logic signed [N-1:0] cos_theta,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] va,
    output logic signed [N-1:0] vb,
    output logic signed [N-1:0] vc
);

    localparam int PW = 2 * N;
    localparam int AW = 2 * N + 1;

    localparam logic signed [N-1:0]  K_OP   = N'(K_SQRT3_2);
    localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (N - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = AW'(-(2 ** (N - 1)));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4,
        S_M4   = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    state_t                r_state;
    logic signed [N-1:0]   r_vd, r_vq, r_sin, r_cos;
    logic signed [N-1:0]   r_valpha, r_vbeta;
    logic signed [N-1:0]   r_va, r_vb, r_vc;
    logic signed [AW-1:0]  r_acc;
    logic                  r_out_valid;

    logic signed [N-1:0]   w_op_a, w_op_b;
    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_prod_ext;
    logic signed [AW-1:0]  w_acc_new;
    logic signed [AW-1:0]  w_acc_shr;
    logic signed [N-1:0]   w_half;
    logic signed [AW-1:0]  w_half_ext;
    logic signed [AW-1:0]  w_t;
    logic signed [AW-1:0]  w_vb_wide, w_vc_wide;

    function automatic logic signed [N-1:0] sat_n(input logic signed [AW-1:0] x);
        if (x > SAT_HI)
            sat_n = {1'b0, {(N-1){1'b1}}};
        else if (x < SAT_LO)
            sat_n = {1'b1, {(N-1){1'b0}}};
        else
            sat_n = x[N-1:0];
    endfunction

    always_comb begin
        w_op_a = r_vd;
        w_op_b = r_cos;
        case (r_state)
            S_M1:    begin w_op_a = r_vq;     w_op_b = r_sin; end
            S_M2:    begin w_op_a = r_vd;     w_op_b = r_sin; end
            S_M3:    begin w_op_a = r_vq;     w_op_b = r_cos; end
            S_M4:    begin w_op_a = r_vbeta;  w_op_b = K_OP;  end
            default: begin w_op_a = r_vd;     w_op_b = r_cos; end
        endcase
    end

    assign w_prod     = PW'(w_op_a) * PW'(w_op_b);
    assign w_prod_ext = AW'(w_prod);
    assign w_acc_new  = (r_state == S_M1) ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    assign w_acc_shr  = w_acc_new >>> F;

    // In M4 the product is vbeta*K; t and half are formed at full width before clamping.
    assign w_half     = r_valpha >>> 1;
    assign w_half_ext = {{(AW-N){w_half[N-1]}}, w_half};
    assign w_t        = w_prod_ext >>> F;
    assign w_vb_wide  = w_t - w_half_ext;
    assign w_vc_wide  = -w_t - w_half_ext;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_vd        <= '0;
            r_vq        <= '0;
            r_sin       <= '0;
            r_cos       <= '0;
            r_acc       <= '0;
            r_valpha    <= '0;
            r_vbeta     <= '0;
            r_va        <= '0;
            r_vb        <= '0;
            r_vc        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_vd    <= vd;
                        r_vq    <= vq;
                        r_sin   <= sin_theta;
                        r_cos   <= cos_theta;
                        r_state <= S_M0;
                    end
                end
                S_M0: begin
                    r_acc   <= w_prod_ext;
                    r_state <= S_M1;
                end
                S_M1: begin
                    r_acc    <= w_acc_new;
                    r_valpha <= sat_n(w_acc_shr);
                    r_state  <= S_M2;
                end
                S_M2: begin
                    r_acc   <= w_prod_ext;
                    r_state <= S_M3;
                end
                S_M3: begin
                    r_acc   <= w_acc_new;
                    r_vbeta <= sat_n(w_acc_shr);
                    r_state <= S_M4;
                end
                S_M4: begin
                    r_va        <= r_valpha;
                    r_vb        <= sat_n(w_vb_wide);
                    r_vc        <= sat_n(w_vc_wide);
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign va        = r_va;
    assign vb        = r_vb;
    assign vc        = r_vc;

endmodule
